// File: rtl/digit_edit_ctrl.sv
// Edit controller for a 4-digit decimal value: view/edit sequencing, commit on
// completion, abort on idle timeout, and a blink mask for the digit being edited.
module digit_edit_ctrl #(
   parameter int unsigned MAX_DIGIT   = 9,
   parameter int unsigned TIMEOUT_CYC = 250000000,
   parameter int unsigned BLINK_HALF  = 12500000,
   parameter int unsigned CNT_W       = 28
) (
   input  logic        clk,
   input  logic        nRst,
   input  logic        inc_pulse,
   input  logic        nxt_pulse,
   output logic [15:0] val,
   output logic [15:0] disp,
   output logic [3:0]  blank_mask,
   output logic        edit_active,
   output logic [1:0]  edit_sel,
   output logic        commit,
   output logic        abort
);

   typedef enum logic {VIEW, EDIT} state_t;

   state_t             state, state_n;
   logic [1:0]         sel, sel_n;
   logic [15:0]        working, working_n;
   logic [15:0]        val_q, val_n;
   logic [CNT_W-1:0]   tcnt, tcnt_n;
   logic [CNT_W-1:0]   bcnt, bcnt_n;
   logic               phase, phase_n;
   logic               commit_q, commit_n;
   logic               abort_q, abort_n;
   logic [3:0]         digit;

   always_ff @(posedge clk) begin
      if (!nRst) begin
         state    <= VIEW;
         sel      <= '0;
         working  <= '0;
         val_q    <= '0;
         tcnt     <= '0;
         bcnt     <= '0;
         phase    <= 1'b0;
         commit_q <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state    <= state_n;
         sel      <= sel_n;
         working  <= working_n;
         val_q    <= val_n;
         tcnt     <= tcnt_n;
         bcnt     <= bcnt_n;
         phase    <= phase_n;
         commit_q <= commit_n;
         abort_q  <= abort_n;
      end
   end

   // Priority in EDIT: nxt over inc over timeout; any pulse restarts both counters.
   always_comb begin
      state_n   = state;
      sel_n     = sel;
      working_n = working;
      val_n     = val_q;
      tcnt_n    = '0;
      bcnt_n    = '0;
      phase_n   = 1'b0;
      commit_n  = 1'b0;
      abort_n   = 1'b0;
      digit     = working[{sel, 2'b00} +: 4];
      case (state)
         VIEW: begin
            sel_n = '0;
            if (nxt_pulse) begin
               state_n   = EDIT;
               working_n = val_q;
            end
         end
         EDIT: begin
            if (nxt_pulse) begin
               if (sel == 2'd3) begin
                  val_n    = working;
                  commit_n = 1'b1;
                  state_n  = VIEW;
                  sel_n    = '0;
               end else begin
                  sel_n = sel + 2'd1;
               end
            end else if (inc_pulse) begin
               working_n[{sel, 2'b00} +: 4] = (digit >= 4'(MAX_DIGIT)) ? 4'd0 : digit + 4'd1;
            end else if (tcnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               state_n = VIEW;
               abort_n = 1'b1;
               sel_n   = '0;
            end else begin
               tcnt_n = tcnt + CNT_W'(1);
               if (bcnt == CNT_W'(BLINK_HALF - 1)) begin
                  phase_n = ~phase;
               end else begin
                  bcnt_n  = bcnt + CNT_W'(1);
                  phase_n = phase;
               end
            end
         end
         default: state_n = VIEW;
      endcase
   end

   always_comb begin
      edit_active = (state == EDIT);
      val         = val_q;
      commit      = commit_q;
      abort       = abort_q;
      disp        = edit_active ? working : val_q;
      edit_sel    = edit_active ? sel : 2'd0;
      blank_mask  = (edit_active && phase) ? (4'b0001 << sel) : 4'b0000;
   end

endmodule

// File: tb/tb_digit_edit_ctrl.sv
// Bench for digit_edit_ctrl: digit-array reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_digit_edit_ctrl;

   localparam int TO   = 20;
   localparam int BH   = 4;
   localparam int MAXD = 9;

   logic        clk = 1'b0;
   logic        nRst = 1'b0;
   logic        inc_pulse = 1'b0;
   logic        nxt_pulse = 1'b0;
   logic [15:0] val, disp;
   logic [3:0]  blank_mask;
   logic        edit_active;
   logic [1:0]  edit_sel;
   logic        commit, abort;

   int checks = 0;
   int failures = 0;
   int n_commit = 0;
   int n_abort = 0;

   int m_val[4];
   int m_work[4];
   bit m_edit = 1'b0;
   int m_sel = 0;
   int m_idle = 0;
   bit m_commit = 1'b0;
   bit m_abort = 1'b0;
   bit mvalid = 1'b0;

   digit_edit_ctrl #(
      .MAX_DIGIT(MAXD),
      .TIMEOUT_CYC(TO),
      .BLINK_HALF(BH),
      .CNT_W(28)
   ) dut (
      .clk(clk),
      .nRst(nRst),
      .inc_pulse(inc_pulse),
      .nxt_pulse(nxt_pulse),
      .val(val),
      .disp(disp),
      .blank_mask(blank_mask),
      .edit_active(edit_active),
      .edit_sel(edit_sel),
      .commit(commit),
      .abort(abort)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: digits as integers, idle cycles counted since the last event.
   always @(posedge clk) begin
      m_commit = 1'b0;
      m_abort  = 1'b0;
      if (!nRst) begin
         m_edit = 1'b0;
         m_sel  = 0;
         m_idle = 0;
         for (int i = 0; i < 4; i++) begin
            m_val[i]  = 0;
            m_work[i] = 0;
         end
      end else if (!m_edit) begin
         if (nxt_pulse) begin
            m_edit = 1'b1;
            m_sel  = 0;
            m_idle = 0;
            m_work = m_val;
         end
      end else if (nxt_pulse) begin
         m_idle = 0;
         if (m_sel < 3) m_sel++;
         else begin
            m_val    = m_work;
            m_commit = 1'b1;
            m_edit   = 1'b0;
            m_sel    = 0;
         end
      end else if (inc_pulse) begin
         m_idle = 0;
         m_work[m_sel] = (m_work[m_sel] + 1) % (MAXD + 1);
      end else begin
         m_idle++;
         if (m_idle == TO) begin
            m_edit  = 1'b0;
            m_abort = 1'b1;
            m_sel   = 0;
         end
      end
      mvalid = 1'b1;
   end

   always @(negedge clk) begin
      logic [15:0] e_val, e_disp;
      logic [3:0]  e_mask;
      if (mvalid) begin
         for (int i = 0; i < 4; i++) begin
            e_val[i*4 +: 4]  = 4'(m_val[i]);
            e_disp[i*4 +: 4] = 4'(m_edit ? m_work[i] : m_val[i]);
         end
         e_mask = (m_edit && ((m_idle / BH) % 2 == 1)) ? 4'(1 << m_sel) : 4'b0000;
         chk("val", val, e_val);
         chk("disp", disp, e_disp);
         chk("blank_mask", 16'(blank_mask), 16'(e_mask));
         chk("edit_active", 16'(edit_active), 16'(m_edit));
         chk("edit_sel", 16'(edit_sel), 16'(m_sel));
         chk("commit", 16'(commit), 16'(m_commit));
         chk("abort", 16'(abort), 16'(m_abort));
         if (commit === 1'b1) n_commit++;
         if (abort === 1'b1) n_abort++;
      end
   end

   task automatic step(input bit a, input bit b, input bit r);
      @(negedge clk);
      inc_pulse = a;
      nxt_pulse = b;
      nRst      = r;
      @(posedge clk);
      #1;
      inc_pulse = 1'b0;
      nxt_pulse = 1'b0;
   endtask

   task automatic rep(input bit a, input bit b, input int n);
      for (int i = 0; i < n; i++) step(a, b, 1'b1);
   endtask

   initial begin
      // reset and inc ignored in VIEW
      rep(1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("lit_reset_val", val, 16'h0000);
      chk("lit_reset_disp", disp, 16'h0000);
      rep(1'b1, 1'b0, 3);
      chk("lit_view_inc_val", val, 16'h0000);
      chk("lit_view_inc_edit", 16'(edit_active), 16'h0);

      // full edit with wrap on digit1
      rep(1'b0, 1'b1, 1);
      rep(1'b1, 1'b0, 3);
      rep(1'b0, 1'b1, 1);
      rep(1'b1, 1'b0, 12);
      rep(1'b0, 1'b1, 2);
      chk("lit_pre_commit_sel", 16'(edit_sel), 16'd3);
      rep(1'b0, 1'b1, 1);
      chk("lit_commit_pulse", 16'(commit), 16'h1);
      chk("lit_commit_val", val, 16'h0023);
      step(1'b0, 1'b0, 1'b1);
      chk("lit_commit_count", 16'(n_commit), 16'd1);

      // timeout abort after 20 idle cycles
      rep(1'b0, 1'b1, 1);
      rep(1'b1, 1'b0, 5);
      chk("lit_work_disp", disp, 16'h0028);
      rep(1'b0, 1'b0, 19);
      chk("lit_no_abort_yet", 16'(abort), 16'h0);
      chk("lit_still_edit", 16'(edit_active), 16'h1);
      rep(1'b0, 1'b0, 1);
      chk("lit_abort_pulse", 16'(abort), 16'h1);
      chk("lit_abort_val", val, 16'h0023);
      chk("lit_abort_disp", disp, 16'h0023);

      // blink on digit1
      rep(1'b0, 1'b1, 2);
      rep(1'b0, 1'b0, 3);
      chk("lit_blink_0", 16'(blank_mask), 16'h0);
      rep(1'b0, 1'b0, 1);
      chk("lit_blink_on", 16'(blank_mask), 16'h2);
      rep(1'b0, 1'b0, 3);
      chk("lit_blink_on2", 16'(blank_mask), 16'h2);
      rep(1'b0, 1'b0, 1);
      chk("lit_blink_off", 16'(blank_mask), 16'h0);
      rep(1'b0, 1'b0, 5);
      chk("lit_blink_on3", 16'(blank_mask), 16'h2);
      rep(1'b1, 1'b0, 1);
      chk("lit_blink_reset", 16'(blank_mask), 16'h0);
      chk("lit_inc_d1", disp, 16'h0033);

      // simultaneous inc and nxt
      rep(1'b0, 1'b1, 3);
      chk("lit_commit2_val", val, 16'h0033);
      rep(1'b0, 1'b1, 1);
      step(1'b1, 1'b1, 1'b1);
      chk("lit_both_sel", 16'(edit_sel), 16'd1);
      chk("lit_both_disp", disp, 16'h0033);

      // reset mid-edit
      rep(1'b0, 1'b1, 3);
      rep(1'b0, 1'b1, 1);
      rep(1'b1, 1'b0, 2);
      chk("lit_pre_reset_disp", disp, 16'h0035);
      step(1'b0, 1'b0, 1'b0);
      chk("lit_rst_val", val, 16'h0000);
      chk("lit_rst_disp", disp, 16'h0000);
      chk("lit_rst_edit", 16'(edit_active), 16'h0);
      chk("lit_rst_commit", 16'(commit), 16'h0);
      chk("lit_rst_abort", 16'(abort), 16'h0);
      step(1'b0, 1'b0, 1'b1);
      chk("lit_commit_total", 16'(n_commit), 16'd3);

      // pulse in the timeout cycle beats the timeout
      rep(1'b0, 1'b1, 1);
      rep(1'b0, 1'b0, 19);
      rep(1'b1, 1'b0, 1);
      chk("lit_pulse_wins_abort", 16'(abort), 16'h0);
      chk("lit_pulse_wins_edit", 16'(edit_active), 16'h1);
      chk("lit_pulse_wins_disp", disp, 16'h0001);
      rep(1'b0, 1'b0, 20);
      chk("lit_abort2", 16'(abort), 16'h1);
      rep(1'b0, 1'b0, 1);
      chk("lit_abort_single", 16'(abort), 16'h0);
      chk("lit_abort_total", 16'(n_abort), 16'd2);
      rep(1'b0, 1'b0, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
